// File: rtl/ex_mem_stage_if.sv
// EX/MEM stage bus: EX-stage operands/controls, WB feedback, ID hazard indices,
// and the registered MEM-stage outputs plus the load-use stall request.
interface ex_mem_stage_if #(
  parameter int unsigned W = 32
);
  // EX-stage operands and indices
  logic [W-1:0] rd1;
  logic [W-1:0] rd2;
  logic [4:0]   rs_e;
  logic [4:0]   rt_e;
  logic [4:0]   rd_e;
  logic [W-1:0] off_e;
  // EX-stage controls
  logic         RegWrite_e;
  logic         RegDSt_e;
  logic         ALUsrc_e;
  logic         MemRead_e;
  logic         MemWrite_e;
  logic         MemtoReg_e;
  logic [3:0]   aluC_e;
  // WB-stage feedback
  logic [W-1:0] wb_data;
  logic [4:0]   wreg_w;
  logic         RegWrite_w;
  // ID-stage indices for load-use detection
  logic [4:0]   rs_d;
  logic [4:0]   rt_d;
  // MEM-stage registered outputs
  logic [W-1:0] alu_m;
  logic [W-1:0] wdata_m;
  logic [4:0]   wreg_m;
  logic         RegWrite_m;
  logic         MemRead_m;
  logic         MemWrite_m;
  logic         MemtoReg_m;
  // Load-use stall request (combinational)
  logic         stall;

  modport master (
    output rd1, rd2, rs_e, rt_e, rd_e, off_e,
           RegWrite_e, RegDSt_e, ALUsrc_e, MemRead_e, MemWrite_e, MemtoReg_e, aluC_e,
           wb_data, wreg_w, RegWrite_w, rs_d, rt_d,
    input  alu_m, wdata_m, wreg_m, RegWrite_m, MemRead_m, MemWrite_m, MemtoReg_m, stall
  );

  modport slave (
    input  rd1, rd2, rs_e, rt_e, rd_e, off_e,
           RegWrite_e, RegDSt_e, ALUsrc_e, MemRead_e, MemWrite_e, MemtoReg_e, aluC_e,
           wb_data, wreg_w, RegWrite_w, rs_d, rt_d,
    output alu_m, wdata_m, wreg_m, RegWrite_m, MemRead_m, MemWrite_m, MemtoReg_m, stall
  );
endinterface

// File: rtl/ex_mem_stage.sv
// Execute stage with MEM/WB operand forwarding, ALU, EX/MEM pipeline register
// and load-use hazard detection for the instruction in ID.
module ex_mem_stage #(
  parameter int unsigned W = 32
) (
  input  logic          clk,
  input  logic          rst,
  ex_mem_stage_if.slave bus
);
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  logic [W-1:0] fwd_a;
  logic [W-1:0] fwd_b;
  logic [W-1:0] op_b;
  logic [W-1:0] alu_res;
  logic [4:0]   wreg_e;
  logic         mem_fwd_ok;
  logic         wb_fwd_ok;

  // A MEM-stage load result is not available yet, so only ALU results forward from MEM
  assign mem_fwd_ok = bus.RegWrite_m && !bus.MemtoReg_m && (bus.wreg_m != 5'd0);
  assign wb_fwd_ok  = bus.RegWrite_w && (bus.wreg_w != 5'd0);

  // Operand forwarding: MEM beats WB, register 0 never forwards
  always_comb begin
    fwd_a = bus.rd1;
    fwd_b = bus.rd2;
    if (mem_fwd_ok && (bus.wreg_m == bus.rs_e)) begin
      fwd_a = bus.alu_m;
    end else if (wb_fwd_ok && (bus.wreg_w == bus.rs_e)) begin
      fwd_a = bus.wb_data;
    end
    if (mem_fwd_ok && (bus.wreg_m == bus.rt_e)) begin
      fwd_b = bus.alu_m;
    end else if (wb_fwd_ok && (bus.wreg_w == bus.rt_e)) begin
      fwd_b = bus.wb_data;
    end
  end

  assign op_b   = bus.ALUsrc_e ? bus.off_e : fwd_b;
  assign wreg_e = bus.RegDSt_e ? bus.rd_e : bus.rt_e;

  // ALU; add/sub wrap silently, unknown codes yield zero
  always_comb begin
    alu_res = '0;
    unique case (bus.aluC_e)
      ALU_AND: alu_res = fwd_a & op_b;
      ALU_OR:  alu_res = fwd_a | op_b;
      ALU_ADD: alu_res = fwd_a + op_b;
      ALU_SUB: alu_res = fwd_a - op_b;
      ALU_SLT: alu_res = ($signed(fwd_a) < $signed(op_b)) ? W'(1) : '0;
      ALU_NOR: alu_res = ~(fwd_a | op_b);
      default: alu_res = '0;
    endcase
  end

  // Load-use hazard: the ID instruction needs the register this load is fetching
  assign bus.stall = bus.MemRead_e && (bus.rt_e != 5'd0) &&
                     ((bus.rt_e == bus.rs_d) || (bus.rt_e == bus.rt_d));

  // EX/MEM pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.alu_m      <= '0;
      bus.wdata_m    <= '0;
      bus.wreg_m     <= 5'd0;
      bus.RegWrite_m <= 1'b0;
      bus.MemRead_m  <= 1'b0;
      bus.MemWrite_m <= 1'b0;
      bus.MemtoReg_m <= 1'b0;
    end else begin
      bus.alu_m      <= alu_res;
      bus.wdata_m    <= fwd_b;
      bus.wreg_m     <= wreg_e;
      bus.RegWrite_m <= bus.RegWrite_e;
      bus.MemRead_m  <= bus.MemRead_e;
      bus.MemWrite_m <= bus.MemWrite_e;
      bus.MemtoReg_m <= bus.MemtoReg_e;
    end
  end
endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: forwarding, ALU ops, hazards, reset.
module tb_ex_mem_stage;
  localparam int unsigned W = 32;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ex_mem_stage_if #(.W(W)) bus ();

  ex_mem_stage #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Quiet all EX/WB/ID inputs
  task automatic idle();
    bus.rd1 = '0; bus.rd2 = '0; bus.off_e = '0;
    bus.rs_e = 5'd0; bus.rt_e = 5'd0; bus.rd_e = 5'd0;
    bus.RegWrite_e = 1'b0; bus.RegDSt_e = 1'b0; bus.ALUsrc_e = 1'b0;
    bus.MemRead_e = 1'b0; bus.MemWrite_e = 1'b0; bus.MemtoReg_e = 1'b0;
    bus.aluC_e = 4'b0010;
    bus.wb_data = '0; bus.wreg_w = 5'd0; bus.RegWrite_w = 1'b0;
    bus.rs_d = 5'd0; bus.rt_d = 5'd0;
  endtask

  // Advance one edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // R-type op with no forwarding, destination rd_e
  task automatic rop(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                     input logic [4:0] dst, input logic wr);
    idle();
    bus.rs_e = 5'd1; bus.rt_e = 5'd2; bus.rd1 = a; bus.rd2 = b;
    bus.aluC_e = op; bus.RegDSt_e = 1'b1; bus.rd_e = dst; bus.RegWrite_e = wr;
  endtask

  logic [31:0] va [8];
  logic [31:0] vb [8];
  logic [3:0]  vop[8];
  logic [31:0] vex[8];

  initial begin
    checks = 0;
    failures = 0;
    idle();
    rst = 1'b1;
    step();
    check("rst_alu_m", bus.alu_m, 32'h0);
    check("rst_regwrite_m", 32'(bus.RegWrite_m), 32'h0);
    rst = 1'b0;

    // Back-to-back ADD dependency through MEM forwarding
    rop(32'd2, 32'd3, 4'b0010, 5'd3, 1'b1);
    step();
    check("add_alu_m", bus.alu_m, 32'd5);
    check("add_wreg_m", 32'(bus.wreg_m), 32'd3);
    check("add_wdata_m", bus.wdata_m, 32'd3);
    check("add_regwrite_m", 32'(bus.RegWrite_m), 32'd1);
    idle();
    bus.rs_e = 5'd3; bus.rd1 = 32'd99; bus.off_e = 32'd2; bus.ALUsrc_e = 1'b1;
    bus.rt_e = 5'd5; bus.RegWrite_e = 1'b1;
    step();
    check("dep_alu_m", bus.alu_m, 32'd7);
    check("dep_wreg_rt", 32'(bus.wreg_m), 32'd5);

    // MEM has priority over WB on the same index
    rop(32'd10, 32'd0, 4'b0010, 5'd4, 1'b1);
    step();
    check("prio_setup", bus.alu_m, 32'd10);
    idle();
    bus.rs_e = 5'd4; bus.rd1 = 32'd77;
    bus.RegWrite_w = 1'b1; bus.wreg_w = 5'd4; bus.wb_data = 32'd20;
    step();
    check("prio_mem_wins", bus.alu_m, 32'd10);
    // MEM now holds a non-writing bubble, so WB forwards
    idle();
    bus.rs_e = 5'd4; bus.rd1 = 32'd77;
    bus.RegWrite_w = 1'b1; bus.wreg_w = 5'd4; bus.wb_data = 32'd20;
    step();
    check("wb_fwd", bus.alu_m, 32'd20);

    // Writes to register 0 never forward
    rop(32'd50, 32'd0, 4'b0010, 5'd0, 1'b1);
    step();
    idle();
    bus.rs_e = 5'd0; bus.rd1 = 32'd11;
    bus.RegWrite_w = 1'b1; bus.wreg_w = 5'd0; bus.wb_data = 32'd20;
    step();
    check("zero_no_fwd", bus.alu_m, 32'd11);

    // Store data forwarded from MEM on operand B
    rop(32'd6, 32'd0, 4'b0010, 5'd9, 1'b1);
    step();
    idle();
    bus.rs_e = 5'd1; bus.rd1 = 32'd100; bus.rt_e = 5'd9; bus.rd2 = 32'd1;
    bus.ALUsrc_e = 1'b1; bus.off_e = 32'd4; bus.MemWrite_e = 1'b1;
    step();
    check("st_addr", bus.alu_m, 32'd104);
    check("st_wdata_fwd", bus.wdata_m, 32'd6);
    check("st_memwrite_m", 32'(bus.MemWrite_m), 32'd1);
    check("st_regwrite_m", 32'(bus.RegWrite_m), 32'd0);

    // A load in MEM must not forward its address
    idle();
    bus.rs_e = 5'd1; bus.rd1 = 32'd40; bus.ALUsrc_e = 1'b1; bus.rt_e = 5'd12;
    bus.MemRead_e = 1'b1; bus.MemtoReg_e = 1'b1; bus.RegWrite_e = 1'b1;
    step();
    check("ld_memread_m", 32'(bus.MemRead_m), 32'd1);
    check("ld_memtoreg_m", 32'(bus.MemtoReg_m), 32'd1);
    idle();
    bus.rs_e = 5'd12; bus.rd1 = 32'd3;
    step();
    check("ld_no_mem_fwd", bus.alu_m, 32'd3);

    // Load-use stall (combinational)
    idle();
    bus.MemRead_e = 1'b1; bus.rt_e = 5'd8; bus.rs_d = 5'd8;
    #1 check("stall_rs", 32'(bus.stall), 32'd1);
    bus.rs_d = 5'd0; bus.rt_d = 5'd8;
    #1 check("stall_rt", 32'(bus.stall), 32'd1);
    bus.rt_e = 5'd0; bus.rt_d = 5'd0;
    #1 check("stall_zero", 32'(bus.stall), 32'd0);
    bus.MemRead_e = 1'b0; bus.rt_e = 5'd8; bus.rs_d = 5'd8;
    #1 check("stall_noload", 32'(bus.stall), 32'd0);

    // ALU operation table
    va[0] = 32'h0000F0F0; vb[0] = 32'h0000FF00; vop[0] = 4'b0000; vex[0] = 32'h0000F000;
    va[1] = 32'h0000F0F0; vb[1] = 32'h0000FF00; vop[1] = 4'b0001; vex[1] = 32'h0000FFF0;
    va[2] = 32'h0000F0F0; vb[2] = 32'h0000FF00; vop[2] = 4'b1100; vex[2] = 32'hFFFF000F;
    va[3] = 32'hFFFFFFFF; vb[3] = 32'h00000001; vop[3] = 4'b0111; vex[3] = 32'h00000001;
    va[4] = 32'h00000001; vb[4] = 32'hFFFFFFFF; vop[4] = 4'b0111; vex[4] = 32'h00000000;
    va[5] = 32'h00000000; vb[5] = 32'h00000001; vop[5] = 4'b0110; vex[5] = 32'hFFFFFFFF;
    va[6] = 32'hFFFFFFFF; vb[6] = 32'h00000002; vop[6] = 4'b0010; vex[6] = 32'h00000001;
    va[7] = 32'h12345678; vb[7] = 32'h00000001; vop[7] = 4'b0011; vex[7] = 32'h00000000;
    for (int i = 0; i < 8; i++) begin
      rop(va[i], vb[i], vop[i], 5'd0, 1'b0);
      step();
      check($sformatf("alu_op%0d", i), bus.alu_m, vex[i]);
    end

    // Bubble clears all MEM controls
    rop(32'd1, 32'd1, 4'b0010, 5'd7, 1'b1);
    bus.MemWrite_e = 1'b1;
    step();
    idle();
    step();
    check("bubble_regwrite", 32'(bus.RegWrite_m), 32'd0);
    check("bubble_memwrite", 32'(bus.MemWrite_m), 32'd0);
    check("bubble_memread", 32'(bus.MemRead_m), 32'd0);

    // Asynchronous reset between edges
    rop(32'd8, 32'd9, 4'b0010, 5'd6, 1'b1);
    step();
    check("pre_rst_regwrite", 32'(bus.RegWrite_m), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_alu_m", bus.alu_m, 32'h0);
    check("async_rst_wreg_m", 32'(bus.wreg_m), 32'h0);
    check("async_rst_regwrite", 32'(bus.RegWrite_m), 32'h0);
    step();
    check("rst_hold_alu_m", bus.alu_m, 32'h0);
    rst = 1'b0;
    step();
    check("post_rst_alu_m", bus.alu_m, 32'd17);
    check("post_rst_wreg_m", 32'(bus.wreg_m), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter W, default 32, data-path width (register data, offset, ALU result).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port rd1  input  W  register-file operand A from ID/EX register.
REQ-005 SHALL have port rd2  input  W  register-file operand B from ID/EX register.
REQ-006 SHALL have port rs_e  input  5  source register index A of EX instruction.
REQ-007 SHALL have port rt_e  input  5  source register index B / I-type destination of EX instruction.
REQ-008 SHALL have port rd_e  input  5  R-type destination index of EX instruction.
REQ-009 SHALL have port off_e  input  W  sign-extended immediate.
REQ-010 SHALL have port RegWrite_e  input  1  EX instruction writes register file.
REQ-011 SHALL have port RegDSt_e  input  1  1 selects rd_e, 0 selects rt_e as destination.
REQ-012 SHALL have port ALUsrc_e  input  1  1 selects off_e, 0 selects forwarded operand B.
REQ-013 SHALL have port MemRead_e  input  1  EX instruction is a load.
REQ-014 SHALL have port MemWrite_e  input  1  EX instruction is a store.
REQ-015 SHALL have port MemtoReg_e  input  1  writeback from memory data.
REQ-016 SHALL have port aluC_e  input  4  ALU operation code.
REQ-017 SHALL have port wb_data  input  W  value being written back by the WB stage.
REQ-018 SHALL have port wreg_w  input  5  WB destination index.
REQ-019 SHALL have port RegWrite_w  input  1  WB stage write enable.
REQ-020 SHALL have port rs_d  input  5  rs index of the instruction in ID.
REQ-021 SHALL have port rt_d  input  5  rt index of the instruction in ID.
REQ-022 SHALL have port alu_m  output  W  registered ALU result (memory address for loads/stores).
REQ-023 SHALL have port wdata_m  output  W  registered store data (forwarded operand B).
REQ-024 SHALL have port wreg_m  output  5  registered destination index.
REQ-025 SHALL have ports RegWrite_m, MemRead_m, MemWrite_m, MemtoReg_m  output  1 each  registered controls.
REQ-026 SHALL have port stall  output  1  combinational load-use stall request to PC/IF-ID and the ID/EX nop input.

Function
REQ-027 SHALL form operand A = fwdA, operand B = ALUsrc_e ? off_e : fwdB.
REQ-028 SHALL forward for fwdA from the MEM stage (alu_m) when RegWrite_m=1, MemtoReg_m=0, wreg_m!=0, wreg_m==rs_e; else from WB (wb_data) when RegWrite_w=1, wreg_w!=0, wreg_w==rs_e; else rd1.
REQ-029 SHALL apply the REQ-028 rules identically for fwdB using rt_e and rd2; MEM forwarding has priority over WB when both match.
REQ-030 SHALL never forward for index 0; register 0 always reads as rd1/rd2 as delivered.
REQ-031 SHALL compute per aluC_e: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1 or 0), 1100 NOR; any other code gives 0.
REQ-032 SHALL wrap ADD/SUB modulo 2^W with no overflow flag or trap.
REQ-033 SHALL select destination wreg = RegDSt_e ? rd_e : rt_e.
REQ-034 SHALL on each rising clk (rst low) load alu_m, wdata_m=fwdB, wreg_m, and the four controls from the EX-stage values; latency exactly 1 cycle.
REQ-035 SHALL assert stall combinationally when MemRead_e=1, rt_e!=0, and (rt_e==rs_d or rt_e==rt_d); otherwise 0.
REQ-036 SHALL pass a bubble (all EX controls 0) to produce RegWrite_m=MemRead_m=MemWrite_m=0 with no side effects.

Reset
REQ-037 SHALL, while rst=1, drive every registered output to 0 immediately, independent of clk.
REQ-038 SHALL let rst win over any simultaneous clock edge; first capture occurs on the first rising clk after rst falls.

Verification
REQ-039 SHALL cover reset mid-stream: rst pulsed between edges with RegWrite_m=1 -> all registered outputs 0 before next edge.
REQ-040 SHALL cover ADD back-to-back dependency: prior result alu_m=5, wreg_m=3, rs_e=3, rd1=99, off_e=2, ALUsrc_e=1, aluC_e=0010 -> next alu_m=7.
REQ-041 SHALL cover priority: wreg_m=wreg_w=4, alu_m=10, wb_data=20, rs_e=4, aluC_e=0010 with operand B 0 -> alu_m=10; and wreg=0 match -> no forwarding.
REQ-042 SHALL cover load-use: MemRead_e=1, rt_e=8, rs_d=8 -> stall=1; rt_e=0, rs_d=0 -> stall=0.
REQ-043 SHALL cover SLT signed and SUB wrap: A=0xFFFFFFFF, B=1, aluC_e=0111 -> alu_m=1; A=0, B=1, aluC_e=0110 -> alu_m=0xFFFFFFFF.
